// File: rtl/arbiter_fcfs.sv
// First-come-first-served PCI arbiter for three masters with active-low REQ#/GNT#.
// Optional ARB_RR_MODE_EN adds a mode port selecting round-robin hand-over on a transaction start.
module arbiter_fcfs (
  input  logic clk,
  input  logic rst,
  input  logic reqA,
  input  logic reqB,
  input  logic reqC,
  input  logic frame,
`ifdef ARB_RR_MODE_EN
  input  logic mode,
`endif
  output logic gntA,
  output logic gntB,
  output logic gntC
);

  localparam int unsigned N  = 3;
  localparam int unsigned IW = 2;
  localparam int unsigned CW = 2;

  logic [IW-1:0] q [N];
  logic [CW-1:0] cnt;
  logic          frame_q;
  logic [2:0]    gnt_q;

  logic [IW-1:0] q_nxt [N];
  logic [CW-1:0] cnt_nxt;
  logic [2:0]    gnt_nxt;

  logic [2:0]    want;
  logic          start;
  logic [IW-1:0] head;
  logic [IW-1:0] wq [N];
  logic [CW-1:0] wc;
  logic [2:0]    inq;
  logic [IW-1:0] nxt;

  assign want = ~{reqC, reqB, reqA};

  // Next queue: start/pop, withdraw, then enqueue new requesters in A,B,C order.
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      wq[i]    = '0;
      q_nxt[i] = '0;
    end
    wc      = cnt;
    cnt_nxt = '0;
    head    = q[0];
    inq     = '0;
    nxt     = '0;
    gnt_nxt = 3'b111;
    start   = !frame && frame_q && (cnt != '0);

    for (int i = 0; i < int'(N); i++) wq[i] = q[i];
    if (start) begin
      for (int i = 0; i < int'(N) - 1; i++) wq[i] = wq[i+1];
      wq[N-1] = '0;
      wc      = wc - CW'(1);
      if (want[head]) begin
        wq[wc] = head;
        wc     = wc + CW'(1);
      end
    end

    for (int i = 0; i < int'(N); i++) begin
      if ((CW'(i) < wc) && want[wq[i]]) begin
        q_nxt[cnt_nxt] = wq[i];
        cnt_nxt        = cnt_nxt + CW'(1);
      end
    end

    for (int i = 0; i < int'(N); i++) begin
      if (CW'(i) < cnt_nxt) inq[q_nxt[i]] = 1'b1;
    end
    for (int m = 0; m < int'(N); m++) begin
      if (want[m] && !inq[m]) begin
        q_nxt[cnt_nxt] = IW'(m);
        cnt_nxt        = cnt_nxt + CW'(1);
      end
    end

`ifdef ARB_RR_MODE_EN
    // Round robin: rebuild the order cyclically starting after the master that just started.
    if (mode && start) begin
      for (int i = 0; i < int'(N); i++) q_nxt[i] = '0;
      cnt_nxt = '0;
      nxt     = head;
      for (int k = 0; k < int'(N); k++) begin
        nxt = (nxt == IW'(2)) ? '0 : nxt + IW'(1);
        if (want[nxt]) begin
          q_nxt[cnt_nxt] = nxt;
          cnt_nxt        = cnt_nxt + CW'(1);
        end
      end
    end
`endif

    if (cnt_nxt != '0) gnt_nxt[q_nxt[0]] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(N); i++) q[i] <= '0;
      cnt     <= '0;
      frame_q <= 1'b1;
      gnt_q   <= 3'b111;
    end else begin
      for (int i = 0; i < int'(N); i++) q[i] <= q_nxt[i];
      cnt     <= cnt_nxt;
      frame_q <= frame;
      gnt_q   <= gnt_nxt;
    end
  end

  assign gntA = gnt_q[0];
  assign gntB = gnt_q[1];
  assign gntC = gnt_q[2];

endmodule

// File: tb/tb_arbiter_fcfs.sv
// Directed, table-driven bench for arbiter_fcfs; expected grants are hand-computed {gntC,gntB,gntA}.
module tb_arbiter_fcfs;

  logic clk = 1'b0;
  logic rst;
  logic reqA, reqB, reqC, frame, mode;
  logic gntA, gntB, gntC;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  arbiter_fcfs dut (
    .clk  (clk),
    .rst  (rst),
    .reqA (reqA),
    .reqB (reqB),
    .reqC (reqC),
    .frame(frame),
`ifdef ARB_RR_MODE_EN
    .mode (mode),
`endif
    .gntA (gntA),
    .gntB (gntB),
    .gntC (gntC)
  );

  typedef struct {
    logic       ra, rb, rc, fr;
    logic [2:0] exp;
  } vec_t;

  vec_t vecs [26];

  task automatic check(input string name, input logic [2:0] exp);
    logic [2:0] act;
    act = {gntC, gntB, gntA};
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: gnt{C,B,A} got %b expected %b", name, act, exp);
  endtask

  // Drive inputs away from the edge, then sample 1 time unit after the rising edge.
  task automatic step(input logic ra, input logic rb, input logic rc, input logic fr);
    @(negedge clk);
    reqA = ra; reqB = rb; reqC = rc; frame = fr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            rA    rB    rC    fr    exp{C,B,A}
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'b110};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'b110};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'b101};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'b101};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'b101};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b110};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'b110};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b111};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b111};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b111};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b111};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b110};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b101};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b101};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b011};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b011};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b110};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b110};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b101};
    vecs[19] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'b011};
    vecs[20] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b111};
    vecs[21] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'b011};
    vecs[22] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b011};
    vecs[23] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b011};
    vecs[24] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b110};
    vecs[25] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b111};

    rst = 1'b1; reqA = 1'b1; reqB = 1'b1; reqC = 1'b1; frame = 1'b1; mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 3'b111);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 26; i++) begin
      step(vecs[i].ra, vecs[i].rb, vecs[i].rc, vecs[i].fr);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Reset while granted and with FRAME# low: grants clear and the low FRAME# is not a start.
    step(1'b0, 1'b1, 1'b1, 1'b1); check("pre_rst_grant", 3'b110);
    @(negedge clk); rst = 1'b1; frame = 1'b0;
    @(posedge clk); #1; check("mid_reset", 3'b111);
    @(negedge clk); rst = 1'b0;
    step(1'b0, 1'b1, 1'b1, 1'b0); check("post_rst_enqueue", 3'b110);
    step(1'b0, 1'b1, 1'b1, 1'b0); check("frame_held", 3'b110);
    step(1'b0, 1'b1, 1'b1, 1'b1); check("frame_high", 3'b110);
    step(1'b0, 1'b1, 1'b1, 1'b0); check("solo_requeue", 3'b110);
    step(1'b1, 1'b1, 1'b1, 1'b1); check("idle", 3'b111);

`ifdef ARB_RR_MODE_EN
    // Round robin: C arrives before B, but B is next after A cyclically.
    mode = 1'b1;
    step(1'b0, 1'b1, 1'b1, 1'b1); check("rr_a", 3'b110);
    step(1'b0, 1'b1, 1'b0, 1'b1); check("rr_c_queued", 3'b110);
    step(1'b0, 1'b0, 1'b0, 1'b1); check("rr_b_queued", 3'b110);
    step(1'b0, 1'b0, 1'b0, 1'b0); check("rr_start_b", 3'b101);
    step(1'b0, 1'b0, 1'b0, 1'b1); check("rr_hold_b", 3'b101);
    step(1'b0, 1'b0, 1'b0, 1'b0); check("rr_start_c", 3'b011);
    step(1'b1, 1'b1, 1'b1, 1'b1); check("rr_idle", 3'b111);
    mode = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
